// File: rtl/cnt_arbiter_pkg.sv
// Shared types and defaults for the counter arbiter: FSM state encoding,
// default requester count and counter width.
package cnt_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 8;

    // Index width for a requester number; never below one bit.
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnt_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req starting one past the last
// granted index and returns the first hit as one-hot plus its index.
module rr_pick
    import cnt_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = idx_width(NREQ_DEF)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic [IW-1:0]   index
);

    int          pos;
    logic [IW-1:0] pos_idx;
    logic        found;

    always_comb begin
        winner  = '0;
        index   = '0;
        found   = 1'b0;
        pos     = 0;
        pos_idx = '0;
        // Offset NREQ wraps back to last itself, so the previous owner is
        // considered only after every other requester.
        for (int i = 1; i <= NREQ; i++) begin
            pos = int'(last) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            pos_idx = IW'(pos);
            if (!found && req[pos_idx]) begin
                found           = 1'b1;
                winner[pos_idx] = 1'b1;
                index           = pos_idx;
            end
        end
    end

endmodule

// File: rtl/cnt_arbiter.sv
// Round-robin owner of a shared up-counter. Each grant runs the counter from 0
// to the owner's latched terminal count, then pulses done.
// Optional macro CNT_ARBITER_ABORT_EN: owner dropping req mid-RUN aborts to IDLE.
//
// state | meaning
// IDLE  | no owner; arbitrate when any req is high
// RUN   | owner holds gnt; count climbs to len_l
// DONE  | one-cycle done pulse to owner, then IDLE
module cnt_arbiter
    import cnt_arbiter_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0][WIDTH-1:0] len,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic                       busy,
    output logic [WIDTH-1:0]           count
);

    localparam int IW = idx_width(NREQ);

    state_t           state;
    logic [IW-1:0]    last;
    logic [WIDTH-1:0] len_l;
    logic [NREQ-1:0]  pick_onehot;
    logic [IW-1:0]    pick_idx;
    logic             abort;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_onehot),
        .index  (pick_idx)
    );

`ifdef CNT_ARBITER_ABORT_EN
    assign abort = ~|(req & gnt);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            gnt   <= '0;
            done  <= '0;
            busy  <= 1'b0;
            count <= '0;
            len_l <= '0;
            last  <= IW'(NREQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= pick_onehot;
                        len_l <= len[pick_idx];
                        count <= '0;
                        last  <= pick_idx;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // last already points at the owner, so an abort leaves
                    // the pointer advanced past it.
                    if (abort) begin
                        gnt   <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (count == len_l) begin
                        done  <= gnt;
                        state <= DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    done  <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
